// File: rtl/io_pkg.sv
// Shared byte/word types and the holding-register state used by the UART word path.
package io_pkg;
  localparam int WORD_BYTES_DEFAULT = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;
endpackage

// File: rtl/word_rx_timer.sv
// Idle counter: counts enabled cycles since the last clear and flags expiry at
// TIMEOUT_CYCLES-1 unless a clear arrives in that same cycle.
module word_rx_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == CW'(TIMEOUT_CYCLES - 1));
  assign o_expire   = i_enable && !i_clear && w_at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_at_limit ? '0 : r_count + 1'b1;
    end
  end
endmodule

// File: rtl/word_rx.sv
// Reassembles LSB-first bytes into words behind a valid/ack holding register.
// Define WORD_RX_TIMEOUT_EN to discard partial words after an idle period.
module word_rx
  import io_pkg::*;
#(
  parameter int WORD_BYTES     = WORD_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  byte_t                   byte_in,
  input  logic                    byte_valid,
  input  logic                    word_ack,
  output logic [8*WORD_BYTES-1:0] word_out,
  output logic                    word_valid,
  output logic                    overrun,
  output logic                    timeout,
  output logic [$clog2(WORD_BYTES)-1:0] byte_count
);
  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] r_byte_count;
  logic [W-1:0]  r_asm;
  logic [W-1:0]  r_word_out;
  logic          r_overrun;
  hold_state_t   r_hold_state;

  hold_state_t   w_hold_next;
  logic [W-1:0]  w_word_next;
  logic          w_overrun_next;
  logic [W-1:0]  w_new_word;
  logic          w_complete;
  logic          w_expire;

  assign w_complete = byte_valid && (r_byte_count == CW'(WORD_BYTES - 1));

  // Final byte goes straight from the input so the word is usable on the completing edge.
  always_comb begin
    w_new_word           = r_asm;
    w_new_word[W-1 -: 8] = byte_in;
  end

`ifdef WORD_RX_TIMEOUT_EN
  logic r_timeout;
  logic w_timer_clear;

  assign w_timer_clear = byte_valid || (r_byte_count == '0);

  word_rx_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_timer_clear),
    .i_enable (1'b1),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_timeout <= 1'b0;
    else     r_timeout <= w_expire;
  end

  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_expire             = 1'b0;
  assign timeout              = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_count <= '0;
      r_asm        <= '0;
    end else if (byte_valid) begin
      r_asm[8*int'(r_byte_count) +: 8] <= byte_in;
      r_byte_count <= w_complete ? '0 : r_byte_count + 1'b1;
    end else if (w_expire) begin
      r_byte_count <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_state <= HOLD_EMPTY;
      r_word_out   <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_hold_state <= w_hold_next;
      r_word_out   <= w_word_next;
      r_overrun    <= w_overrun_next;
    end
  end

  always_comb begin
    w_hold_next    = r_hold_state;
    w_word_next    = r_word_out;
    w_overrun_next = 1'b0;
    case (r_hold_state)
      HOLD_EMPTY: begin
        if (w_complete) begin
          w_hold_next = HOLD_FULL;
          w_word_next = w_new_word;
        end
      end
      HOLD_FULL: begin
        if (w_complete) begin
          // An ack on the completing edge frees the slot just in time for the new word.
          if (word_ack) w_word_next    = w_new_word;
          else          w_overrun_next = 1'b1;
        end else if (word_ack) begin
          w_hold_next = HOLD_EMPTY;
        end
      end
      default: w_hold_next = HOLD_EMPTY;
    endcase
  end

  assign word_out   = r_word_out;
  assign word_valid = (r_hold_state == HOLD_FULL);
  assign overrun    = r_overrun;
  assign byte_count = r_byte_count;
endmodule

// File: tb/tb_word_rx.sv
// Bench for word_rx: scoreboard of expected words plus per-scenario inline checks.
module tb_word_rx;
  import io_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  byte_t      byte_in;
  logic       byte_valid;
  logic       word_ack;
  word_t      word_out;
  logic       word_valid;
  logic       overrun;
  logic       timeout;
  logic [1:0] byte_count;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_q[$];

  // Reference model of the receiver.
  logic  tb_full = 1'b0;
  int    tb_bc   = 0;
  word_t tb_asm  = '0;

  logic mon_ack_edge   = 1'b0;
  logic mon_prev_valid = 1'b0;

  always #5 clk = ~clk;

  word_rx #(
    .WORD_BYTES     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .word_ack   (word_ack),
    .word_out   (word_out),
    .word_valid (word_valid),
    .overrun    (overrun),
    .timeout    (timeout),
    .byte_count (byte_count)
  );

  always @(posedge clk) mon_ack_edge <= word_ack;

  // A word is loaded when valid rises, or stays high across an acked edge.
  always @(negedge clk) begin
    if (!rst && word_valid && (!mon_prev_valid || mon_ack_edge)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_load: got unexpected word %h, none expected", word_out);
      end else begin
        logic [31:0] exp_w;
        exp_w = exp_q.pop_front();
        if (word_out !== exp_w) begin
          errors++;
          $display("FAIL word_load: got %h, expected %h", word_out, exp_w);
        end
      end
    end
    mon_prev_valid = word_valid;
  end

  task automatic apply_reset();
    rst        = 1'b1;
    byte_valid = 1'b0;
    word_ack   = 1'b0;
    byte_in    = '0;
    tb_full    = 1'b0;
    tb_bc      = 0;
    tb_asm     = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input byte_t b, input logic ack);
    logic exp_ovr;
    exp_ovr    = 1'b0;
    byte_in    = b;
    byte_valid = 1'b1;
    word_ack   = ack;
    tb_asm[8*tb_bc +: 8] = b;
    if (tb_bc == 3) begin
      if (!tb_full || ack) begin
        exp_q.push_back(tb_asm);
        tb_full = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
      tb_bc = 0;
    end else begin
      tb_bc++;
      if (ack) tb_full = 1'b0;
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    word_ack   = 1'b0;
    vectors++;
    if (overrun !== exp_ovr) begin
      errors++;
      $display("FAIL overrun: got %b, expected %b", overrun, exp_ovr);
    end
    vectors++;
    if (byte_count !== tb_bc[1:0]) begin
      errors++;
      $display("FAIL byte_count: got %0d, expected %0d", byte_count, tb_bc);
    end
    vectors++;
    if (word_valid !== tb_full) begin
      errors++;
      $display("FAIL word_valid: got %b, expected %b", word_valid, tb_full);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    word_ack = 1'b1;
    @(posedge clk);
    #1 word_ack = 1'b0;
    tb_full = 1'b0;
    vectors++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: word_valid got %b, expected 0", word_valid);
    end
  endtask

  task automatic send_word(input word_t w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b0);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    byte_valid = 1'b0;
    word_ack   = 1'b0;
    byte_in    = '0;
    #3;
    vectors++;
    if ({word_valid, overrun, timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 000", {word_valid, overrun, timeout});
    end
    vectors++;
    if (word_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_word: got %h, expected 00000000", word_out);
    end
    vectors++;
    if (byte_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, expected 0", byte_count);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    send_word(32'h12345678, 2);
    do_ack();
  endtask

  task automatic test_back_to_back();
    vectors++;
    if (byte_count !== 2'd0) begin
      errors++;
      $display("FAIL b2b_start_count: got %0d, expected 0", byte_count);
    end
    send_word(32'hDDCCBBAA, 0);
    do_ack();
  endtask

  task automatic test_overrun();
    send_word(32'h12345678, 0);
    send_word(32'h04030201, 0);
    vectors++;
    if (word_out !== 32'h12345678) begin
      errors++;
      $display("FAIL overrun_hold: got %h, expected 12345678", word_out);
    end
    idle(1);
    vectors++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pulse_width: got %b, expected 0", overrun);
    end
  endtask

  task automatic test_simul_ack();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    vectors++;
    if (word_out !== 32'h04030201) begin
      errors++;
      $display("FAIL simul_ack_word: got %h, expected 04030201", word_out);
    end
    do_ack();
  endtask

  task automatic test_reset_midword();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    apply_reset();
    vectors++;
    if (byte_count !== 2'd0) begin
      errors++;
      $display("FAIL midword_reset_count: got %0d, expected 0", byte_count);
    end
    send_word(32'h12345678, 1);
    do_ack();
  endtask

  task automatic test_timeout();
    logic exp_t;
    send_byte(8'h11, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
`ifdef WORD_RX_TIMEOUT_EN
      exp_t = (i == 15);
`else
      exp_t = 1'b0;
`endif
      vectors++;
      if (timeout !== exp_t) begin
        errors++;
        $display("FAIL timeout_pulse: cycle %0d got %b, expected %b", i, timeout, exp_t);
      end
    end
`ifdef WORD_RX_TIMEOUT_EN
    tb_bc = 0;
`endif
    vectors++;
    if (byte_count !== tb_bc[1:0]) begin
      errors++;
      $display("FAIL timeout_count: got %0d, expected %0d", byte_count, tb_bc);
    end
    send_word(32'h12345678, 0);
    do_ack();
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_simul_ack();
    test_reset_midword();
    test_timeout();
    idle(2);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d words left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
